led_pulse_stretcher: RTL and testbench

- Output-side counterpart to the button input path: accepts single-cycle event pulses from `clock`-domain logic and drives a board LED.
- Each event becomes one human-visible blink: an ON period followed by an OFF gap.
- Events arriving during a blink are queued in a saturating counter, so N events produce N distinct blinks.
- Sits between control logic and the LED pin.

---
 rtl/led_pulse_stretcher_pkg.sv | 25 ++
 rtl/led_pulse_stretcher_cycle_timer.sv | 30 +++
 rtl/led_pulse_stretcher.sv | 153 +++++++++++++++
 tb/tb_led_pulse_stretcher.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/led_pulse_stretcher_pkg.sv
// Shared constants for the LED pulse stretcher: state encoding, board-clock blink defaults, PWM width.
// The optional brightness feature in the top is enabled by defining LED_PWM_EN.
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 50 ms on / 50 ms off at the 100 MHz board clock
  localparam int DEF_ON_CYCLES  = 32'd5000000;
  localparam int DEF_GAP_CYCLES = 32'd5000000;

  localparam int PWM_W = 32'd8;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_cycle_timer.sv
// Loadable down-counter: load overrides, otherwise counts toward zero and holds there.
// done is high whenever the count has reached zero.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count_r;

  // count register: reload on request, decrement without wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle event pulses into visible LED blinks (ON then GAP), queueing extra events.
// Define LED_PWM_EN to add a duty input that dims the LED during ON.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int PEND_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]  duty,
`endif
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int TW = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);
  // Timer holds remaining cycles minus one so done marks the final cycle of a phase
  localparam logic [TW-1:0]     ON_LOAD   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};

  state_t            state_r, state_s;
  logic              timer_load_s;
  logic [TW-1:0]     timer_val_s;
  logic              timer_done_s;
  logic [PEND_W-1:0] pending_r, pending_s;
  logic              overflow_r, overflow_s;
  logic              led_r, led_on_s;
  logic              busy_r;

  cycle_timer #(.W(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load_s),
    .value (timer_val_s),
    .done  (timer_done_s)
  );

  // next state, timer reload and event queue bookkeeping
  always_comb begin
    state_s      = state_r;
    timer_load_s = 1'b0;
    timer_val_s  = ON_LOAD;
    pending_s    = pending_r;
    overflow_s   = overflow_r;
    case (state_r)
      IDLE: begin
        if (in) begin
          state_s      = ON;
          timer_load_s = 1'b1;
          timer_val_s  = ON_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if (timer_done_s) begin
          state_s      = GAP;
          timer_load_s = 1'b1;
          timer_val_s  = GAP_LOAD;
        end else begin
          state_s = ON;
        end
        if (in && (pending_r == PEND_MAX)) begin
          overflow_s = 1'b1;
        end else if (in) begin
          pending_s = pending_r + PEND_ONE;
        end else begin
          pending_s = pending_r;
        end
      end
      GAP: begin
        if (timer_done_s) begin
          // A new event and a consumed one cancel, so the queue never overflows here
          if ((pending_r != PEND_ZERO) || in) begin
            state_s      = ON;
            timer_load_s = 1'b1;
            timer_val_s  = ON_LOAD;
            if (!in) begin
              pending_s = pending_r - PEND_ONE;
            end else begin
              pending_s = pending_r;
            end
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = GAP;
          if (in && (pending_r == PEND_MAX)) begin
            overflow_s = 1'b1;
          end else if (in) begin
            pending_s = pending_r + PEND_ONE;
          end else begin
            pending_s = pending_r;
          end
        end
      end
      default: begin
        state_s      = IDLE;
        timer_load_s = 1'b1;
        timer_val_s  = ON_LOAD;
      end
    endcase
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_r;

  // free-running brightness counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= {PWM_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
    end
  end

  assign led_on_s = (state_s == ON) && (pwm_cnt_r < duty);
`else
  assign led_on_s = (state_s == ON);
`endif

  // state, queue and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pending_r  <= PEND_ZERO;
      overflow_r <= 1'b0;
      led_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pending_r  <= pending_s;
      overflow_r <= overflow_s;
      led_r      <= led_on_s;
      busy_r     <= (state_s != IDLE);
    end
  end

  assign led      = led_r;
  assign busy     = busy_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2.
// Observations are taken 1 time unit after each rising edge; "k" counts edges since the first pulse.
module tb_led_pulse_stretcher;

  localparam int ON_C  = 4;
  localparam int GAP_C = 3;
  localparam int PW    = 2;

  logic          clock;
  logic          reset;
  logic          in;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;
`ifdef LED_PWM_EN
  logic [7:0]    duty;
`endif

  int n_checks;
  int n_fails;
  int rises;
  logic prev_led;

  led_pulse_stretcher #(
    .ON_CYCLES  (ON_C),
    .GAP_CYCLES (GAP_C),
    .PEND_W     (PW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
`ifdef LED_PWM_EN
    .duty     (duty),
`endif
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic b,
                         input logic [PW-1:0] p, input logic o);
    chk({tag, ".led"}, {31'd0, led}, {31'd0, l});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".pending"}, {30'd0, pending}, {30'd0, p});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, o});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    in       = 1'b0;
`ifdef LED_PWM_EN
    duty     = 8'd255;
`endif
    tick();
    tick();
    chk_all("in_reset", 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    chk_all("idle_after_reset", 1'b0, 1'b0, 2'd0, 1'b0);

    // single pulse: led k=1..4, busy k=1..7, idle at k=8
    in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      in = 1'b0;
      chk_all($sformatf("single_k%0d", k), (k <= 4), (k <= 7), 2'd0, 1'b0);
    end

    // three back-to-back pulses: three blinks, busy falls at k=22
    in = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      logic          el;
      logic [PW-1:0] ep;
      tick();
      in = (k < 3);
      el = ((k >= 1) && (k <= 4)) || ((k >= 8) && (k <= 11)) || ((k >= 15) && (k <= 18));
      if (k == 1)       ep = 2'd0;
      else if (k == 2)  ep = 2'd1;
      else if (k <= 7)  ep = 2'd2;
      else if (k <= 14) ep = 2'd1;
      else              ep = 2'd0;
      chk_all($sformatf("triple_k%0d", k), el, (k <= 21), ep, 1'b0);
    end

    // asynchronous reset while lit: outputs clear before the next edge
    in = 1'b1;
    tick();
    in = 1'b1;
    tick();
    in = 1'b0;
    chk_all("pre_reset_lit", 1'b1, 1'b1, 2'd1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("post_reset_idle%0d", k), 1'b0, 1'b0, 2'd0, 1'b0);
    end

    // pulse on the last GAP cycle with one queued event: two further blinks
    in = 1'b1;
    tick();
    in = 1'b1;
    tick();
    in = 1'b0;
    chk("lastgap.pending_k2", {30'd0, pending}, 32'd1);
    for (int k = 3; k <= 7; k++) begin
      tick();
    end
    in = 1'b1;
    tick();
    in = 1'b0;
    chk_all("lastgap_k8", 1'b1, 1'b1, 2'd1, 1'b0);
    rises = 1;
    prev_led = led;
    for (int k = 9; k <= 30; k++) begin
      tick();
      if (led && !prev_led) rises++;
      prev_led = led;
    end
    chk("lastgap.further_blinks", rises, 32'd2);
    chk_all("lastgap_end", 1'b0, 1'b0, 2'd0, 1'b0);

    // overflow: five consecutive pulses, queue saturates at 3, four blinks
    in = 1'b1;
    rises = 0;
    prev_led = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      in = (k < 5);
      if (led && !prev_led) rises++;
      prev_led = led;
      if (k == 4) chk_all("ovf_k4", 1'b1, 1'b1, 2'd3, 1'b0);
      if (k == 5) chk_all("ovf_k5", 1'b0, 1'b1, 2'd3, 1'b1);
    end
    chk("ovf.blinks", rises, 32'd4);
    chk_all("ovf_end", 1'b0, 1'b0, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
